// File: rtl/rotary_seq_pkg.sv
// rotary_seq_pkg
// Shared types and constants for the rotary cell-culture chip sequencer:
// FSM state and command-op enums, valve levels, the peristaltic pump
// pattern table and the channel-to-mux-pair decode.
package rotary_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PUMP,
        ST_CLOSE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_MIX    = 2'd1,
        OP_UNLOAD = 2'd2,
        OP_RSVD   = 2'd3
    } op_t;

    localparam logic VALVE_OPEN   = 1'b0;
    localparam logic VALVE_CLOSED = 1'b1;

    localparam logic [2:0] LAST_STEP = 3'd5;

    // Pump pattern {A, B, C}; entry 0 is the first step of a rotation.
    localparam logic [5:0][2:0] PUMP_PAT = {
        3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101
    };

    // Returns {branch pair, leaf pair} for a mux channel.
    function automatic logic [3:0] chan_pairs(input logic [1:0] c);
        return {~c[1], c[1], ~c[0], c[0]};
    endfunction

endpackage

// File: rtl/rotary_seq_ctrl_phase_timer.sv
// phase_timer
// Loadable down-counter. Loading value D-1 makes expire pulse for one cycle
// in the D-th cycle after the load; a load in the expire cycle restarts it.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load, load_val  start a new hold of load_val+1 cycles
//   expire          high during the last cycle of the hold
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;
    logic             armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= load_val;
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign expire = armed & (cnt == '0);

endmodule

// File: rtl/rotary_seq_ctrl.sv
// rotary_seq_ctrl
// Turns load / mix / unload commands into timed pneumatic valve patterns for
// the rotary cell-culture chip (inlet mux, mixer pump + isolation valves,
// outlet mux). Line level 1 = pressurised / valve closed.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_op, cmd_chan, cmd_count  operation, trap channel, pump rotations
//   abort                        cut SETUP/PUMP short, finish with err
//   busy, done, err              progress / completion pulse / error flag
//   cb1..cb6                     registered valve control lines
//
// state | meaning
// IDLE  | waiting for a command, all lines closed
// SETUP | routing pattern held, pump closed, settle timer running
// PUMP  | peristaltic steps, one every PHASE_CYCLES
// CLOSE | all lines closed for the settle time
// DONE  | one-cycle completion pulse
module rotary_seq_ctrl
    import rotary_seq_pkg::*;
#(
    parameter int PHASE_CYCLES  = 1000,
    parameter int SETTLE_CYCLES = 500,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_chan,
    input  logic [7:0] cmd_count,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] cb1,
    output logic [1:0] cb2,
    output logic [2:0] cb3,
    output logic [1:0] cb4,
    output logic [1:0] cb5,
    output logic [1:0] cb6
);

    localparam logic [CNT_W-1:0] PHASE_LD  = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    op_t        op_q, op_nxt;
    logic [1:0] chan_q, chan_nxt;
    logic [7:0] count_q, count_nxt;
    logic [2:0] step_q, step_nxt;
    logic [7:0] rot_q, rot_nxt;
    logic       err_q, err_nxt;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expire;

    logic [1:0] cb1_nxt, cb2_nxt, cb4_nxt, cb5_nxt, cb6_nxt;
    logic [2:0] cb3_nxt;
    logic [2:0] pat;
    logic [3:0] pairs;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_LOAD;
            chan_q    <= '0;
            count_q   <= '0;
            step_q    <= '0;
            rot_q     <= '0;
            err_q     <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cb1       <= {2{VALVE_CLOSED}};
            cb2       <= {2{VALVE_CLOSED}};
            cb3       <= {3{VALVE_CLOSED}};
            cb4       <= {2{VALVE_CLOSED}};
            cb5       <= {2{VALVE_CLOSED}};
            cb6       <= {2{VALVE_CLOSED}};
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            chan_q    <= chan_nxt;
            count_q   <= count_nxt;
            step_q    <= step_nxt;
            rot_q     <= rot_nxt;
            err_q     <= err_nxt;
            cmd_ready <= (state_nxt == ST_IDLE);
            busy      <= (state_nxt == ST_SETUP) || (state_nxt == ST_PUMP) ||
                         (state_nxt == ST_CLOSE);
            done      <= (state_nxt == ST_DONE);
            err       <= (state_nxt == ST_DONE) && err_nxt;
            cb1       <= cb1_nxt;
            cb2       <= cb2_nxt;
            cb3       <= cb3_nxt;
            cb4       <= cb4_nxt;
            cb5       <= cb5_nxt;
            cb6       <= cb6_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        chan_nxt  = chan_q;
        count_nxt = count_q;
        step_nxt  = step_q;
        rot_nxt   = rot_q;
        err_nxt   = err_q;
        tmr_load  = 1'b0;
        tmr_val   = SETTLE_LD;

        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_nxt    = op_t'(cmd_op);
                    chan_nxt  = cmd_chan;
                    count_nxt = cmd_count;
                    step_nxt  = '0;
                    rot_nxt   = '0;
                    if (op_t'(cmd_op) == OP_RSVD) begin
                        state_nxt = ST_DONE;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_SETUP;
                        err_nxt   = 1'b0;
                        tmr_load  = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_nxt = ST_CLOSE;
                    err_nxt   = 1'b1;
                    tmr_load  = 1'b1;
                end else if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (count_q == 8'd0) begin
                        state_nxt = ST_CLOSE;
                    end else begin
                        state_nxt = ST_PUMP;
                        tmr_val   = PHASE_LD;
                        step_nxt  = '0;
                        rot_nxt   = '0;
                    end
                end
            end
            ST_PUMP: begin
                if (abort) begin
                    state_nxt = ST_CLOSE;
                    err_nxt   = 1'b1;
                    tmr_load  = 1'b1;
                end else if (tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = PHASE_LD;
                    if (step_q != LAST_STEP) begin
                        step_nxt = step_q + 3'd1;
                    end else if (rot_q == count_q - 8'd1) begin
                        state_nxt = ST_CLOSE;
                        tmr_val   = SETTLE_LD;
                    end else begin
                        step_nxt = '0;
                        rot_nxt  = rot_q + 8'd1;
                    end
                end
            end
            ST_CLOSE: begin
                if (tmr_expire) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output patterns are decoded from the next state so that the registered
    // lines change exactly on state/step transitions.
    always_comb begin
        cb1_nxt = {2{VALVE_CLOSED}};
        cb2_nxt = {2{VALVE_CLOSED}};
        cb3_nxt = {3{VALVE_CLOSED}};
        cb4_nxt = {2{VALVE_CLOSED}};
        cb5_nxt = {2{VALVE_CLOSED}};
        cb6_nxt = {2{VALVE_CLOSED}};
        pat     = {3{VALVE_CLOSED}};
        pairs   = chan_pairs(chan_nxt);

        if (state_nxt == ST_PUMP) begin
            pat = PUMP_PAT[step_nxt];
        end

        if ((state_nxt == ST_SETUP) || (state_nxt == ST_PUMP)) begin
            cb3_nxt[1] = pat[0];
            cb4_nxt    = {pat[1], pat[2]};
            case (op_nxt)
                OP_LOAD: begin
                    cb1_nxt    = pairs[3:2];
                    cb2_nxt    = pairs[1:0];
                    cb3_nxt[0] = VALVE_OPEN;
                end
                OP_UNLOAD: begin
                    cb5_nxt    = pairs[3:2];
                    cb6_nxt    = pairs[1:0];
                    cb3_nxt[2] = VALVE_OPEN;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotary_seq_ctrl.sv
// Testbench for rotary_seq_ctrl with P=2, S=3. Each command's expected
// per-cycle trace is built from the operational rules (settle, rotations of
// six pump steps, close, done) and compared with the sampled DUT outputs.
// Trace vector: {cb1,cb2,cb3,cb4,cb5,cb6, cmd_ready, busy, done, err}.
module tb_rotary_seq_ctrl;

    localparam int P = 2;
    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_chan;
    logic [7:0] cmd_count;
    logic       abort;
    logic       busy, done, err;
    logic [1:0] cb1, cb2, cb4, cb5, cb6;
    logic [2:0] cb3;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    logic [2:0]  pump_abc[6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    localparam logic [16:0] IDLE_VEC = {13'h1FFF, 4'b1000};

    rotary_seq_ctrl #(
        .PHASE_CYCLES (P),
        .SETTLE_CYCLES(S),
        .CNT_W        (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_chan  (cmd_chan),
        .cmd_count (cmd_count),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cb1       (cb1),
        .cb2       (cb2),
        .cb3       (cb3),
        .cb4       (cb4),
        .cb5       (cb5),
        .cb6       (cb6)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] vec_now();
        return {cb1, cb2, cb3, cb4, cb5, cb6, cmd_ready, busy, done, err};
    endfunction

    // Reference model: expected trace starting at the cycle after acceptance.
    task automatic build_exp(input int op, input int chan, input int count, input int abort_at);
        logic [12:0] route, ln;
        logic [1:0]  c;
        logic        e;
        exp_q.delete();
        c = chan[1:0];
        e = (op == 3);
        if (op != 3) begin
            route = 13'h1FFF;
            if (op == 0) begin
                route[12:11] = {~c[1], c[1]};
                route[10:9]  = {~c[0], c[0]};
                route[6]     = 1'b0;
            end else if (op == 2) begin
                route[3:2] = {~c[1], c[1]};
                route[1:0] = {~c[0], c[0]};
                route[8]   = 1'b0;
            end
            for (int i = 0; i < S; i++) exp_q.push_back({route, 4'b0100});
            for (int r = 0; r < count; r++)
                for (int s = 0; s < 6; s++)
                    for (int p = 0; p < P; p++) begin
                        ln      = route;
                        ln[7]   = pump_abc[s][0];
                        ln[5:4] = {pump_abc[s][1], pump_abc[s][2]};
                        exp_q.push_back({ln, 4'b0100});
                    end
            if (abort_at >= 0 && abort_at < exp_q.size()) begin
                while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
                e = 1'b1;
            end
            for (int i = 0; i < S; i++) exp_q.push_back({13'h1FFF, 4'b0100});
        end
        exp_q.push_back({13'h1FFF, 2'b00, 1'b1, e});
        exp_q.push_back(IDLE_VEC);
    endtask

    // Offers a command, then samples one vector per cycle for the whole
    // expected trace. With hold set, cmd_valid stays high with junk fields
    // until the final (idle) cycle.
    task automatic run_cmd(input int op, input int chan, input int count,
                           input int abort_at, input bit hold);
        build_exp(op, chan, count, abort_at);
        obs_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op[1:0];
        cmd_chan  = chan[1:0];
        cmd_count = count[7:0];
        @(posedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            obs_q.push_back(vec_now());
            abort = (i == abort_at);
            if (hold && i < exp_q.size() - 1) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_chan  = 2'($urandom_range(0, 3));
                cmd_count = 8'($urandom_range(0, 255));
            end else begin
                cmd_valid = 1'b0;
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (vec_now() !== IDLE_VEC) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", vec_now(), IDLE_VEC);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (vec_now() !== IDLE_VEC) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", vec_now(), IDLE_VEC);
        end
    endtask

    task automatic test_load();
        run_cmd(0, 2, 1, -1, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL load_trace cyc=%0d got=%h exp=%h", i + 1, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q[0][16:4] !== 13'b01_10_110_11_11_11) begin
            failures++;
            $display("FAIL load_route got=%b exp=%b", obs_q[0][16:4], 13'b01_10_110_11_11_11);
        end
        checks++;
        if (obs_q[18][1:0] !== 2'b10) begin
            failures++;
            $display("FAIL load_done_cyc19 got=%b exp=10", obs_q[18][1:0]);
        end
    endtask

    task automatic test_mix_zero();
        run_cmd(1, int'($urandom_range(0, 3)), 0, -1, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL mix0_trace cyc=%0d got=%h exp=%h", i + 1, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q[6][1] !== 1'b1) begin
            failures++;
            $display("FAIL mix0_done_cyc7 got=%b exp=1", obs_q[6][1]);
        end
    endtask

    task automatic test_unload();
        run_cmd(2, 1, 2, -1, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL unload_trace cyc=%0d got=%h exp=%h", i + 1, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q[0][16:4] !== 13'b11_11_011_11_10_01) begin
            failures++;
            $display("FAIL unload_route got=%b exp=%b", obs_q[0][16:4], 13'b11_11_011_11_10_01);
        end
        checks++;
        if (obs_q[30][1] !== 1'b1) begin
            failures++;
            $display("FAIL unload_done_cyc31 got=%b exp=1", obs_q[30][1]);
        end
    endtask

    task automatic test_abort();
        run_cmd(0, 3, 2, S + 4, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL abort_trace cyc=%0d got=%h exp=%h", i + 1, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q[S + 5][16:4] !== 13'h1FFF) begin
            failures++;
            $display("FAIL abort_closed got=%b exp=all ones", obs_q[S + 5][16:4]);
        end
        checks++;
        if (obs_q[S + 8][1:0] !== 2'b11) begin
            failures++;
            $display("FAIL abort_done_err got=%b exp=11", obs_q[S + 8][1:0]);
        end
    endtask

    task automatic test_reserved();
        run_cmd(3, 2, 5, -1, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rsvd_trace cyc=%0d got=%h exp=%h", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(0, 1, 1, -1, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_first cyc=%0d got=%h exp=%h", i + 1, obs_q[i], exp_q[i]);
            end
        end
        run_cmd(2, 0, 1, -1, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_second cyc=%0d got=%h exp=%h", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int op, chan, count, ab, len;
        for (int n = 0; n < 20; n++) begin
            op    = int'($urandom_range(0, 3));
            chan  = int'($urandom_range(0, 3));
            count = int'($urandom_range(0, 3));
            ab    = -1;
            len   = S + 6 * P * count;
            if (op != 3 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(0, len - 1));
            run_cmd(op, chan, count, ab, bit'($urandom_range(0, 1)));
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_trace n=%0d op=%0d cyc=%0d got=%h exp=%h",
                             n, op, i + 1, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pump();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_chan  = 2'd3;
        cmd_count = 8'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy got=%b exp=1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (vec_now() !== IDLE_VEC) begin
                failures++;
                $display("FAIL rstmid_idle cyc=%0d got=%h exp=%h", i, vec_now(), IDLE_VEC);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_chan  = '0;
        cmd_count = '0;
        abort     = 1'b0;
        test_reset();
        test_load();
        test_mix_zero();
        test_unload();
        test_abort();
        test_reserved();
        test_back_to_back();
        test_reset_mid_pump();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
